// File: rtl/riscv_ctrl_pkg.sv
// Shared states, opcodes, select encodings and per-state control word for multicycle_ctrl.
// The TRAP state is only reachable when CTRL_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StTrap
  } state_e;

  localparam logic [6:0] OpcodeLw    = 7'b0000011;
  localparam logic [6:0] OpcodeSw    = 7'b0100011;
  localparam logic [6:0] OpcodeRtype = 7'b0110011;
  localparam logic [6:0] OpcodeItype = 7'b0010011;
  localparam logic [6:0] OpcodeBeq   = 7'b1100011;
  localparam logic [6:0] OpcodeJal   = 7'b1101111;

  typedef enum logic [1:0] {
    AluOpAdd,
    AluOpSub,
    AluOpFunct
  } alu_op_e;

  localparam logic [2:0] AluCtlAdd = 3'b000;
  localparam logic [2:0] AluCtlSub = 3'b001;
  localparam logic [2:0] AluCtlAnd = 3'b010;
  localparam logic [2:0] AluCtlOr  = 3'b011;
  localparam logic [2:0] AluCtlSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    alu_op_e    alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_w;
    logic       mem_w;
    logic       reg_w;
  } ctrl_t;

  // Moore control word for a state; opcode only matters for the lw/sw immediate in MEMADR.
  function automatic ctrl_t state_ctrl(state_e st, logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.alu_src_a  = SrcAPc;
        c.alu_src_b  = SrcBFour;
        c.alu_op     = AluOpAdd;
        c.result_src = ResAluResult;
        c.ir_w       = 1'b1;
        c.pc_update  = 1'b1;
      end
      StDecode: begin
        c.alu_src_a = SrcAOldPc;
        c.alu_src_b = SrcBImm;
        c.imm_src   = ImmB;
      end
      StMemAdr: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpAdd;
        c.imm_src   = (opcode == OpcodeSw) ? ImmS : ImmI;
      end
      StMemRead: c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = ResData;
        c.reg_w      = 1'b1;
      end
      StMemWrite: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBRd2;
        c.alu_op    = AluOpFunct;
      end
      StExecI: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBImm;
        c.imm_src   = ImmI;
        c.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        c.result_src = ResAluOut;
        c.reg_w      = 1'b1;
      end
      StBeq: begin
        c.alu_src_a  = SrcARd1;
        c.alu_src_b  = SrcBRd2;
        c.alu_op     = AluOpSub;
        c.result_src = ResAluOut;
        c.branch     = 1'b1;
      end
      StJal: begin
        c.alu_src_a  = SrcAOldPc;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluOut;
        c.pc_update  = 1'b1;
        c.imm_src    = ImmJ;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from alu_op, funct3, funct7b5 and opcode[5].
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtlAdd;
    case (alu_op)
      AluOpAdd: alu_control = AluCtlAdd;
      AluOpSub: alu_control = AluCtlSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type (op5=1) can encode sub; addi with imm[10] set stays add.
          3'b000:  alu_control = (op5 & funct7b5) ? AluCtlSub : AluCtlAdd;
          3'b010:  alu_control = AluCtlSlt;
          3'b110:  alu_control = AluCtlOr;
          3'b111:  alu_control = AluCtlAnd;
          default: alu_control = AluCtlAdd;
        endcase
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32I subset core with memory wait-state support.
// Define CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_w,
  output logic       adr_src,
  output logic       mem_w,
  output logic       ir_w,
  output logic       reg_w,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   mem_rdy;

  assign mem_rdy = mem_ready | ~USE_MEM_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpcodeLw, OpcodeSw: state_d = StMemAdr;
          OpcodeRtype:        state_d = StExecR;
          OpcodeItype:        state_d = StExecI;
          OpcodeBeq:          state_d = StBeq;
          OpcodeJal:          state_d = StJal;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:            state_d = StTrap;
`else
          default:            state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = (opcode == OpcodeSw) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_rdy) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_rdy) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  // The control word of the state being entered is registered with it, so every
  // select comes straight from a flop.
  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state_q <= StFetch;
      ctrl_q  <= state_ctrl(StFetch, OpcodeLw);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d, opcode);
    end
  end

  // ir_w is set only in FETCH, so it also marks which pc_update must wait for memory.
  assign ir_w  = srst & ctrl_q.ir_w & mem_rdy;
  assign pc_w  = srst & ((ctrl_q.pc_update & (mem_rdy | ~ctrl_q.ir_w)) |
                         (ctrl_q.branch & zero));
  assign mem_w = srst & ctrl_q.mem_w;
  assign reg_w = srst & ctrl_q.reg_w;

  assign adr_src    = ctrl_q.adr_src;
  assign result_src = ctrl_q.result_src;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign imm_src    = ctrl_q.imm_src;

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_control (alu_control)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      illegal_q <= 1'b0;
    end else if (state_d == StTrap) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction streams
// checked cycle by cycle against a per-instruction step table.
module tb_multicycle_ctrl;

  localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KBeq = 4, KJal = 5, KBad = 6;

  logic       clk;
  logic       srst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_w, adr_src, mem_w, ir_w, reg_w, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  int         n_cmp;
  int         n_err;
  bit         ill_exp;
  bit         ir_pending;
  logic [6:0] pend_opc;
  logic [2:0] pend_f3;
  bit         pend_f7;

  multicycle_ctrl #(
    .USE_MEM_READY (1'b1)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_w        (pc_w),
    .adr_src     (adr_src),
    .mem_w       (mem_w),
    .ir_w        (ir_w),
    .reg_w       (reg_w),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int kind_of(logic [6:0] opc);
    case (opc)
      7'b0000011: return KLw;
      7'b0100011: return KSw;
      7'b0110011: return KR;
      7'b0010011: return KI;
      7'b1100011: return KBeq;
      7'b1101111: return KJal;
      default:    return KBad;
    endcase
  endfunction

  // Expected ALU control for an R/I-type instruction.
  function automatic int alu_ref(logic [2:0] f3, bit f7, bit is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_ir(input logic [6:0] opc, input logic [2:0] f3, input bit f7);
    pend_opc   = opc;
    pend_f3    = f3;
    pend_f7    = f7;
    ir_pending = 1'b1;
  endtask

  // One cycle: drive inputs, then check outputs; a negative select means don't care.
  task automatic cyc(input string tag, input bit mr, input bit z, input logic [3:0] en,
                     input int adr, input int rs, input int sa, input int sb,
                     input int imm, input int aluc);
    @(negedge clk);
    if (ir_pending) begin
      opcode     = pend_opc;
      funct3     = pend_f3;
      funct7b5   = pend_f7;
      ir_pending = 1'b0;
    end
    mem_ready = mr;
    zero      = z;
    #1;
    chk({tag, ".en"}, {4'b0, pc_w, ir_w, mem_w, reg_w}, {4'b0, en});
    chk({tag, ".illegal"}, {7'b0, illegal}, {7'b0, ill_exp});
    if (adr >= 0)  chk({tag, ".adr_src"}, {7'b0, adr_src}, 8'(adr));
    if (rs >= 0)   chk({tag, ".result_src"}, {6'b0, result_src}, 8'(rs));
    if (sa >= 0)   chk({tag, ".alu_src_a"}, {6'b0, alu_src_a}, 8'(sa));
    if (sb >= 0)   chk({tag, ".alu_src_b"}, {6'b0, alu_src_b}, 8'(sb));
    if (imm >= 0)  chk({tag, ".imm_src"}, {6'b0, imm_src}, 8'(imm));
    if (aluc >= 0) chk({tag, ".alu_control"}, {5'b0, alu_control}, 8'(aluc));
  endtask

  task automatic fetch(input int stalls);
    for (int i = 0; i < stalls; i++) cyc("fetch_wait", 1'b0, rb(), 4'b0000, 0, 2, 0, 2, -1, 0);
    cyc("fetch", 1'b1, rb(), 4'b1100, 0, 2, 0, 2, -1, 0);
  endtask

  task automatic mem_wait(input string tag, input int stalls, input logic [3:0] en);
    for (int i = 0; i < stalls; i++) cyc({tag, "_wait"}, 1'b0, rb(), en, 1, -1, -1, -1, -1, -1);
    cyc(tag, 1'b1, rb(), en, 1, -1, -1, -1, -1, -1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    srst      = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b1;
    ill_exp   = 1'b0;
    #1;
    chk({tag, ".en"}, {4'b0, pc_w, ir_w, mem_w, reg_w}, 8'h00);
    chk({tag, ".illegal"}, {7'b0, illegal}, 8'h00);
    chk({tag, ".adr_src"}, {7'b0, adr_src}, 8'h00);
    chk({tag, ".alu_src_b"}, {6'b0, alu_src_b}, 8'h02);
    chk({tag, ".result_src"}, {6'b0, result_src}, 8'h02);
    @(posedge clk);
    #1;
    chk({tag, ".en_held"}, {4'b0, pc_w, ir_w, mem_w, reg_w}, 8'h00);
    @(negedge clk);
    mem_ready = 1'b0;
    zero      = 1'b0;
    srst      = 1'b1;
  endtask

  // Reference: expected per-cycle outputs for one complete instruction.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input bit f7,
                           input bit z, input int fs, input int ms);
    int k;
    k = kind_of(opc);
    load_ir(opc, f3, f7);
    fetch(fs);
    cyc("decode", rb(), rb(), 4'b0000, -1, -1, 1, 1, 2, -1);
    case (k)
      KLw: begin
        cyc("memadr_lw", rb(), rb(), 4'b0000, -1, -1, 2, 1, 0, 0);
        mem_wait("memread", ms, 4'b0000);
        cyc("memwb", rb(), rb(), 4'b0001, -1, 1, -1, -1, -1, -1);
      end
      KSw: begin
        cyc("memadr_sw", rb(), rb(), 4'b0000, -1, -1, 2, 1, 1, 0);
        mem_wait("memwrite", ms, 4'b0010);
      end
      KR: begin
        cyc("execr", rb(), rb(), 4'b0000, -1, -1, 2, 0, -1, alu_ref(f3, f7, 1'b1));
        cyc("aluwb", rb(), rb(), 4'b0001, -1, 0, -1, -1, -1, -1);
      end
      KI: begin
        cyc("execi", rb(), rb(), 4'b0000, -1, -1, 2, 1, 0, alu_ref(f3, f7, 1'b0));
        cyc("aluwb", rb(), rb(), 4'b0001, -1, 0, -1, -1, -1, -1);
      end
      KBeq: cyc("beq", rb(), z, {z, 3'b000}, -1, 0, 2, 0, -1, 1);
      KJal: begin
        cyc("jal", rb(), rb(), 4'b1000, -1, 0, 1, 2, 3, -1);
        cyc("aluwb", rb(), rb(), 4'b0001, -1, 0, -1, -1, -1, -1);
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill_exp = 1'b1;
        for (int i = 0; i < 4; i++) cyc("trap", rb(), rb(), 4'b0000, -1, -1, -1, -1, -1, -1);
        do_reset("trap_exit");
`endif
      end
    endcase
  endtask

  initial begin
    logic [6:0] legal [6];
    logic [6:0] o;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    n_cmp = 0; n_err = 0; ill_exp = 1'b0; ir_pending = 1'b0;
    srst = 1'b0; opcode = 7'h00; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    pend_opc = 7'h00; pend_f3 = 3'b000; pend_f7 = 1'b0;

    do_reset("por");

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);  // lw, no stalls
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);  // sub
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);  // and
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);  // addi with bit30 set stays add
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 1, 0);  // slti with a fetch stall
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);  // beq not taken
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);  // sw, 3 wait states
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);  // jal

    // Abort a lw while stalled in MEMREAD, then fetch must wait for memory.
    load_ir(7'b0000011, 3'b010, 1'b0);
    fetch(1);
    cyc("decode", rb(), rb(), 4'b0000, -1, -1, 1, 1, 2, -1);
    cyc("memadr_lw", rb(), rb(), 4'b0000, -1, -1, 2, 1, 0, 0);
    cyc("memread_wait", 1'b0, rb(), 4'b0000, 1, -1, -1, -1, -1, -1);
    cyc("memread_wait", 1'b0, rb(), 4'b0000, 1, -1, -1, -1, -1, -1);
    do_reset("rst_memread");
    run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 2, 0);

    // Abort a sw while mem_w is high.
    load_ir(7'b0100011, 3'b010, 1'b0);
    fetch(0);
    cyc("decode", rb(), rb(), 4'b0000, -1, -1, 1, 1, 2, -1);
    cyc("memadr_sw", rb(), rb(), 4'b0000, -1, -1, 2, 1, 1, 0);
    cyc("memwrite_wait", 1'b0, rb(), 4'b0010, 1, -1, -1, -1, -1, -1);
    do_reset("rst_memwrite");

    run_instr(7'h7f, 3'b000, 1'b0, 1'b0, 0, 0);       // unsupported opcode
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      o = legal[$urandom_range(0, 5)];
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 6) == 0) begin
        o = 7'($urandom);
        if (kind_of(o) != KBad) o = 7'h7f;
      end
`endif
      run_instr(o, 3'($urandom), rb(), rb(), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
